// File: rtl/cp0_regfile_if.sv
// Commit-side bundle between the pipeline and the CP0 register file:
// MTC0 writes, exception/ERET commit, interrupt lines and the CP0 snapshot.
interface cp0_regfile_if;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          exc_valid;
    logic [4:0]    exc_code;
    logic [31:0]   exc_pc;
    logic          exc_bd;
    logic          exc_bad_en;
    logic [31:0]   exc_bad_va;
    logic          eret;
    logic [5:0]    ext_int;
    logic [223:0]  cp0;
    logic          int_req;
    logic [31:0]   epc_out;

    modport master (
        output wr_en, wr_addr, wr_data, exc_valid, exc_code, exc_pc, exc_bd,
               exc_bad_en, exc_bad_va, eret, ext_int,
        input  cp0, int_req, epc_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, exc_valid, exc_code, exc_pc, exc_bd,
               exc_bad_en, exc_bad_va, eret, ext_int,
        output cp0, int_req, epc_out
    );
endinterface

// File: rtl/cp0_regfile.sv
// Architectural CP0 state: MTC0 commit, Count/Compare timer, interrupt
// detection, exception entry and ERET. The snapshot on bus.cp0 is registered.
module cp0_regfile #(
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic          clk,
    input  logic          resetn,
    cp0_regfile_if.slave  bus
);

    localparam logic [0:0] DIV_LAST = 1'(COUNT_DIV - 1);

    logic [31:0] badvaddr_r, count_r, compare_r, status_r, epc_r, errorepc_r;
    logic [31:0] badvaddr_s, count_s, compare_s, status_s, epc_s, errorepc_s;
    logic        bd_r, ti_r, int_req_r;
    logic        bd_s, ti_s, int_req_s;
    logic [5:0]  ip_hw_r, ip_hw_s;
    logic [1:0]  ip_sw_r, ip_sw_s;
    logic [4:0]  exc_code_r, exc_code_s;
    logic [0:0]  div_r, div_s;
    logic [31:0] cause_s;
    logic        exc_take_s, eret_take_s, wr_take_s;

    assign cause_s = {bd_r, ti_r, 14'd0, ip_hw_r, ip_sw_r, 1'b0, exc_code_r, 2'b00};

    assign exc_take_s  = bus.exc_valid;
    assign eret_take_s = ~bus.exc_valid & bus.eret;
    assign wr_take_s   = ~bus.exc_valid & ~bus.eret & bus.wr_en;

    // Next-state for every CP0 register; priority exception > ERET > MTC0.
    always_comb begin
        badvaddr_s = badvaddr_r;
        count_s    = count_r;
        compare_s  = compare_r;
        status_s   = status_r;
        epc_s      = epc_r;
        errorepc_s = errorepc_r;
        bd_s       = bd_r;
        ti_s       = ti_r;
        ip_sw_s    = ip_sw_r;
        exc_code_s = exc_code_r;
        div_s      = div_r;

        // A Count write restarts the divider so the new value holds a full period.
        if (wr_take_s && (bus.wr_addr == 5'd9)) begin
            count_s = bus.wr_data;
            div_s   = 1'b0;
        end else if (div_r == DIV_LAST) begin
            count_s = count_r + 32'd1;
            div_s   = 1'b0;
        end else begin
            div_s   = div_r + 1'b1;
        end

        if (wr_take_s && (bus.wr_addr == 5'd11)) begin
            ti_s = 1'b0;
        end else if (count_r == compare_r) begin
            ti_s = 1'b1;
        end else begin
            ti_s = ti_r;
        end

        ip_hw_s = {bus.ext_int[5] | ti_s, bus.ext_int[4:0]};

        if (exc_take_s) begin
            exc_code_s = bus.exc_code;
            // A nested exception keeps the original return point.
            if (!status_r[1]) begin
                epc_s = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
                bd_s  = bus.exc_bd;
            end else begin
                epc_s = epc_r;
                bd_s  = bd_r;
            end
            status_s[1] = 1'b1;
            if (bus.exc_bad_en) begin
                badvaddr_s = bus.exc_bad_va;
            end else begin
                badvaddr_s = badvaddr_r;
            end
        end else if (eret_take_s) begin
            status_s[1] = 1'b0;
        end else if (wr_take_s) begin
            case (bus.wr_addr)
                5'd11:   compare_s  = bus.wr_data;
                5'd12:   status_s   = bus.wr_data;
                5'd13:   ip_sw_s    = bus.wr_data[9:8];
                5'd14:   epc_s      = bus.wr_data;
                5'd30:   errorepc_s = bus.wr_data;
                default: begin end
            endcase
        end else begin
            status_s = status_r;
        end

        int_req_s = status_r[0] & ~status_r[1] & (|(cause_s[15:8] & status_r[15:8]));
    end

    // CP0 state registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr_r <= 32'd0;
            count_r    <= 32'd0;
            compare_r  <= 32'd0;
            status_r   <= STATUS_RST;
            epc_r      <= 32'd0;
            errorepc_r <= 32'd0;
            bd_r       <= 1'b0;
            ti_r       <= 1'b0;
            ip_hw_r    <= 6'd0;
            ip_sw_r    <= 2'd0;
            exc_code_r <= 5'd0;
            div_r      <= 1'b0;
            int_req_r  <= 1'b0;
        end else begin
            badvaddr_r <= badvaddr_s;
            count_r    <= count_s;
            compare_r  <= compare_s;
            status_r   <= status_s;
            epc_r      <= epc_s;
            errorepc_r <= errorepc_s;
            bd_r       <= bd_s;
            ti_r       <= ti_s;
            ip_hw_r    <= ip_hw_s;
            ip_sw_r    <= ip_sw_s;
            exc_code_r <= exc_code_s;
            div_r      <= div_s;
            int_req_r  <= int_req_s;
        end
    end

    assign bus.cp0     = {badvaddr_r, count_r, compare_r, status_r, cause_s, epc_r, errorepc_r};
    assign bus.int_req = int_req_r;
    assign bus.epc_out = epc_r;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: stimulus queues expected values, a negedge
// monitor pops and compares them against the snapshot.
module tb_cp0_regfile;

    localparam int SEL_ERREPC = 0, SEL_EPC = 1, SEL_CAUSE = 2, SEL_STATUS = 3,
                   SEL_COMPARE = 4, SEL_COUNT = 5, SEL_BADVA = 6, SEL_INTREQ = 7,
                   SEL_EPCOUT = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] mask;
        logic [31:0] exp;
    } chk_t;

    logic clk;
    logic resetn;
    logic obs_valid;
    int   checks;
    int   errors;
    chk_t sb_q[$];

    cp0_regfile_if bus ();

    cp0_regfile #(.COUNT_DIV(2), .STATUS_RST(32'h0040_0000)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observed(input int sel);
        case (sel)
            SEL_INTREQ:  return {31'd0, bus.int_req};
            SEL_EPCOUT:  return bus.epc_out;
            default:     return bus.cp0[sel*32 +: 32];
        endcase
    endfunction

    // Monitor: drain the scoreboard whenever the bench marks the snapshot observable.
    always @(negedge clk) begin
        if (obs_valid) begin
            while (sb_q.size() > 0) begin
                chk_t c;
                logic [31:0] act;
                c   = sb_q.pop_front();
                act = observed(c.sel);
                checks = checks + 1;
                if ((act & c.mask) !== (c.exp & c.mask)) begin
                    errors = errors + 1;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (mask 0x%08h)",
                             c.name, act & c.mask, c.exp & c.mask, c.mask);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] mask,
                              input logic [31:0] exp);
        chk_t c;
        c.name = name; c.sel = sel; c.mask = mask; c.exp = exp;
        sb_q.push_back(c);
    endtask

    task automatic observe();
        obs_valid = 1'b1;
        @(negedge clk);
        #1;
        obs_valid = 1'b0;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL monitor_drain: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        step(1);
        bus.wr_en = 1'b0;
    endtask

    task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                             input logic bad_en, input logic [31:0] va);
        bus.exc_valid = 1'b1; bus.exc_code = code; bus.exc_pc = pc;
        bus.exc_bd = bd; bus.exc_bad_en = bad_en; bus.exc_bad_va = va;
    endtask

    task automatic clear_inputs();
        bus.wr_en = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0;
        bus.exc_valid = 1'b0; bus.exc_code = 5'd0; bus.exc_pc = 32'd0;
        bus.exc_bd = 1'b0; bus.exc_bad_en = 1'b0; bus.exc_bad_va = 32'd0;
        bus.eret = 1'b0;
    endtask

    task automatic expect_reset_state(input string tag);
        expect_val({tag, "_status"},   SEL_STATUS,  32'hFFFF_FFFF, 32'h0040_0000);
        expect_val({tag, "_count"},    SEL_COUNT,   32'hFFFF_FFFF, 32'h0);
        expect_val({tag, "_compare"},  SEL_COMPARE, 32'hFFFF_FFFF, 32'h0);
        expect_val({tag, "_cause"},    SEL_CAUSE,   32'hFFFF_FFFF, 32'h0);
        expect_val({tag, "_epc"},      SEL_EPC,     32'hFFFF_FFFF, 32'h0);
        expect_val({tag, "_errorepc"}, SEL_ERREPC,  32'hFFFF_FFFF, 32'h0);
        expect_val({tag, "_badvaddr"}, SEL_BADVA,   32'hFFFF_FFFF, 32'h0);
        expect_val({tag, "_int_req"},  SEL_INTREQ,  32'h1,         32'h0);
    endtask

    initial begin
        checks = 0; errors = 0; obs_valid = 1'b0;
        resetn = 1'b0;
        clear_inputs();
        bus.ext_int = 6'd0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // 1. reset state, then Count advances once per two cycles
        expect_reset_state("rst");
        observe();
        step(10);
        expect_val("count_div", SEL_COUNT, 32'hFFFF_FFFF, 32'd5);
        observe();

        // 2. timer match sets TI and IP7
        mtc0(5'd11, 32'h10);
        mtc0(5'd9, 32'h0E);
        step(4);
        expect_val("count_at_match", SEL_COUNT, 32'hFFFF_FFFF, 32'h10);
        expect_val("ti_before",      SEL_CAUSE, 32'h4000_8000, 32'h0);
        observe();
        step(1);
        expect_val("ti_set", SEL_CAUSE, 32'h4000_8000, 32'h4000_8000);
        observe();
        mtc0(5'd12, 32'h0000_8001);
        expect_val("int_req_latency", SEL_INTREQ, 32'h1, 32'h0);
        observe();
        step(1);
        expect_val("int_req_timer", SEL_INTREQ, 32'h1, 32'h1);
        observe();
        mtc0(5'd11, 32'h1000);
        expect_val("ti_cleared", SEL_CAUSE, 32'h4000_8000, 32'h0);
        observe();
        step(1);
        expect_val("int_req_cleared", SEL_INTREQ, 32'h1, 32'h0);
        observe();

        // 3. exception from a delay slot with bad address
        raise_exc(5'd4, 32'hBFC0_0104, 1'b1, 1'b1, 32'h13);
        step(1);
        clear_inputs();
        expect_val("exc_epc",      SEL_EPC,    32'hFFFF_FFFF, 32'hBFC0_0100);
        expect_val("exc_bd",       SEL_CAUSE,  32'h8000_0000, 32'h8000_0000);
        expect_val("exc_code",     SEL_CAUSE,  32'h0000_007C, 32'h4 << 2);
        expect_val("exc_badvaddr", SEL_BADVA,  32'hFFFF_FFFF, 32'h13);
        expect_val("exc_status",   SEL_STATUS, 32'hFFFF_FFFF, 32'h0000_8003);
        observe();

        // 4. nested exception keeps EPC/BD; ERET returns to the first EPC
        raise_exc(5'd5, 32'h200, 1'b0, 1'b0, 32'hFFFF_FFFF);
        step(1);
        clear_inputs();
        expect_val("nest_epc",   SEL_EPC,   32'hFFFF_FFFF, 32'hBFC0_0100);
        expect_val("nest_bd",    SEL_CAUSE, 32'h8000_0000, 32'h8000_0000);
        expect_val("nest_code",  SEL_CAUSE, 32'h0000_007C, 32'h5 << 2);
        expect_val("nest_badva", SEL_BADVA, 32'hFFFF_FFFF, 32'h13);
        observe();
        bus.eret = 1'b1;
        step(1);
        bus.eret = 1'b0;
        expect_val("eret_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h0000_8001);
        expect_val("eret_target", SEL_EPCOUT, 32'hFFFF_FFFF, 32'hBFC0_0100);
        observe();

        // 5. exception beats ERET and MTC0 in the same cycle
        raise_exc(5'd6, 32'h300, 1'b0, 1'b0, 32'h0);
        bus.eret = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h0;
        step(1);
        clear_inputs();
        expect_val("prio_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h0000_8003);
        expect_val("prio_epc",    SEL_EPC,    32'hFFFF_FFFF, 32'h300);
        observe();
        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_val("cause_wmask", SEL_CAUSE, 32'hFFFF_FFFF, 32'h0000_0318);
        observe();
        mtc0(5'd8, 32'hDEAD_BEEF);
        mtc0(5'd30, 32'hCAFE_0001);
        mtc0(5'd14, 32'h0000_1234);
        mtc0(5'd7, 32'h5555_5555);
        expect_val("badva_readonly", SEL_BADVA,  32'hFFFF_FFFF, 32'h13);
        expect_val("errorepc_wr",    SEL_ERREPC, 32'hFFFF_FFFF, 32'hCAFE_0001);
        expect_val("epc_wr",         SEL_EPCOUT, 32'hFFFF_FFFF, 32'h0000_1234);
        expect_val("addr7_noeffect", SEL_STATUS, 32'hFFFF_FFFF, 32'h0000_8003);
        observe();
        bus.eret = 1'b1;
        step(1);
        bus.eret = 1'b0;

        // 6. Count wrap, hardware interrupt, async reset during an exception
        mtc0(5'd9, 32'hFFFF_FFFF);
        step(1);
        expect_val("count_hold", SEL_COUNT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        observe();
        step(1);
        expect_val("count_wrap", SEL_COUNT, 32'hFFFF_FFFF, 32'h0);
        observe();
        bus.ext_int = 6'b000001;
        mtc0(5'd12, 32'h0000_0401);
        expect_val("ip2_sampled", SEL_CAUSE,  32'h0000_0400, 32'h0000_0400);
        expect_val("hw_int_lat",  SEL_INTREQ, 32'h1,         32'h0);
        observe();
        step(1);
        expect_val("hw_int_req", SEL_INTREQ, 32'h1, 32'h1);
        observe();
        raise_exc(5'd12, 32'h8000_0040, 1'b1, 1'b1, 32'h77);
        bus.ext_int = 6'd0;
        #2 resetn = 1'b0;
        step(1);
        expect_reset_state("midrst");
        observe();
        clear_inputs();
        step(1);
        resetn = 1'b1;
        expect_reset_state("post");
        expect_val("post_epc_out", SEL_EPCOUT, 32'hFFFF_FFFF, 32'h0);
        observe();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
